dmem_stage: RTL

Multi-cycle data-memory stage for the single-issue RISC-V datapath. It sits directly downstream of the execute stage. It consumes the ALU address, store data and the memread/memwrite controls, and adds configurable wait-state latency. While an access is in flight it raises `stall` to freeze PC and upstream state. It performs sub-word loads and stores, then hands `readdata` to writeback.

---
 rtl/dmem_stage_if.sv | 23 ++
 rtl/dmem_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dmem_stage_if.sv
// Bus between the execute stage and the data-memory stage: request fields in,
// registered load result and completion/stall status out.
interface dmem_stage_if;
    logic [31:0] address;
    logic [31:0] writedata;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
    logic [31:0] readdata;
    logic        valid;
    logic        fault;
    logic        stall;

    modport master (
        output address, writedata, memread, memwrite, funct3,
        input  readdata, valid, fault, stall
    );

    modport slave (
        input  address, writedata, memread, memwrite, funct3,
        output readdata, valid, fault, stall
    );
endinterface

// File: rtl/dmem_stage.sv
// Multi-cycle data-memory stage with programmable wait states and upstream stall.
// Define DMEM_SUBWORD_EN to build byte/half loads and stores; otherwise only LW/SW are legal.
//
// state  | meaning
// IDLE   | waiting for memread/memwrite; requests are checked and latched here
// BUSY   | wait-state countdown; memory access happens on the edge where count is 0
// DONE   | valid (and fault) pulse; returns to IDLE unconditionally
module dmem_stage #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    dmem_stage_if.slave bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [3:0]       r_count;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_wdata;
    logic             r_read;
    logic             r_write;
    logic             r_fault;
    logic [31:0]      r_readdata;
`ifdef DMEM_SUBWORD_EN
    logic [1:0]       r_lane;
    logic [2:0]       r_funct3;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
`endif

    logic        w_req;
    logic        w_fault;
    logic        w_range_bad;
    logic        w_align_bad;
    logic        w_f3_bad;
    logic        w_mem_we;
    logic [31:0] w_word;
    logic [31:0] w_load;
    logic [31:0] w_store;
    logic [31:0] w_words [DEPTH_WORDS];

    assign w_req       = bus.memread | bus.memwrite;
    assign w_range_bad = {2'b00, bus.address[31:2]} >= 32'(DEPTH_WORDS);

`ifdef DMEM_SUBWORD_EN
    // Unsigned sizes (BU/HU) exist only for loads.
    always_comb begin
        w_align_bad = 1'b0;
        w_f3_bad    = 1'b0;
        case (bus.funct3)
            3'd0: w_align_bad = 1'b0;
            3'd1: w_align_bad = bus.address[0];
            3'd2: w_align_bad = |bus.address[1:0];
            3'd4: w_f3_bad    = bus.memwrite;
            3'd5: begin
                w_align_bad = bus.address[0];
                w_f3_bad    = bus.memwrite;
            end
            default: w_f3_bad = 1'b1;
        endcase
    end
`else
    assign w_align_bad = |bus.address[1:0];
    assign w_f3_bad    = bus.funct3 != 3'd2;
`endif

    assign w_fault = (bus.memread & bus.memwrite) | w_range_bad | w_align_bad | w_f3_bad;

    assign w_word = w_words[r_idx];

`ifdef DMEM_SUBWORD_EN
    always_comb begin
        w_byte = w_word[{r_lane, 3'b000} +: 8];
        w_half = r_lane[1] ? w_word[31:16] : w_word[15:0];
        case (r_funct3)
            3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_load = {{16{w_half[15]}}, w_half};
            3'd4:    w_load = {24'd0, w_byte};
            3'd5:    w_load = {16'd0, w_half};
            default: w_load = w_word;
        endcase
        // Sub-word stores merge into the current word so untouched lanes survive.
        w_store = w_word;
        case (r_funct3)
            3'd0: w_store[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
            3'd1: begin
                if (r_lane[1]) w_store[31:16] = r_wdata[15:0];
                else           w_store[15:0]  = r_wdata[15:0];
            end
            default: w_store = r_wdata;
        endcase
    end
`else
    assign w_load  = w_word;
    assign w_store = r_wdata;
`endif

    assign w_mem_we = !rst && (r_state == S_BUSY) && (r_count == 4'd0) && r_write;

    // Each word powers up holding its own index and ignores rst.
    for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_word
        logic [31:0] r_word = 32'(g);
        always_ff @(posedge clk) begin
            if (w_mem_we && (r_idx == IDX_W'(g))) begin
                r_word <= w_store;
            end
        end
        assign w_words[g] = r_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= 4'd0;
            r_readdata <= 32'd0;
            r_fault    <= 1'b0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_idx   <= bus.address[IDX_W+1:2];
                        r_wdata <= bus.writedata;
                        r_read  <= bus.memread;
                        r_write <= bus.memwrite;
                        r_fault <= w_fault;
`ifdef DMEM_SUBWORD_EN
                        r_lane   <= bus.address[1:0];
                        r_funct3 <= bus.funct3;
`endif
                        if (w_fault) begin
                            if (bus.memread) r_readdata <= 32'd0;
                            r_state <= S_DONE;
                        end else begin
                            r_count <= 4'(LATENCY);
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        if (r_read) r_readdata <= w_load;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_fault <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.valid    = (r_state == S_DONE);
    assign bus.fault    = (r_state == S_DONE) & r_fault;
    assign bus.stall    = !rst & (((r_state == S_IDLE) & w_req) | (r_state == S_BUSY));
endmodule
